// File: rtl/pll_seq_pkg.sv
// Shared types and default timing for the PLL lock sequencer.
package pll_seq_pkg;

   // Sequencer phases, encoded in 3 bits so the state can be exported as a plain vector.
   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } pll_state_t;

   // Defaults for a 50 MHz reference: 20 ms lock timeout, ~20 us lock qualification.
   localparam int unsigned DEF_RST_PULSE_CYC    = 16;
   localparam int unsigned DEF_LOCK_STABLE_CYC  = 1024;
   localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 1000000;
   localparam int unsigned DEF_MAX_RETRIES      = 7;

   // Largest value the 4-bit retry counter can hold before it saturates.
   localparam logic [3:0] RETRY_SAT = 4'd15;

   // Largest of three cycle counts; sizes the shared phase counter.
   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for slow asynchronous status lines.
// Resets to zero, so a line reads "inactive" until it has been sampled twice.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // First flop may go metastable; the second gives it a full cycle to settle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer on the free-running reference clock.
// Pulses the PLL reset, waits for lock with a timeout, qualifies lock for a
// run of consecutive cycles, then releases system reset. Lock loss or a
// relock request in RUN restarts the sequence; repeated timeouts end in FAULT.
//
// Outputs are a registered decode of the next state, so every output changes
// on the same edge as the state it belongs to.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
   parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
   parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
   parameter int unsigned MAX_RETRIES      = DEF_MAX_RETRIES
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked_i,
   input  logic       relock_req_i,
   output logic       pll_rst_o,
   output logic       sys_rst_n_o,
   output logic       pll_ready_o,
   output logic       fault_o,
   output logic [3:0] retry_cnt_o,
   output logic [2:0] fsm_state
);

   localparam int unsigned CNT_W =
      $clog2(max3(RST_PULSE_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC)) + 1;

   // Terminal counts: cnt starts at 0 on state entry, so N cycles end at N-1.
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [3:0]       MAX_R    = 4'(MAX_RETRIES);

   pll_state_t       state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [3:0]       retry_next;
   logic             lk_s;

   // The PLL lock output is asynchronous to refclk; never use it raw.
   sync_2ff #(.WIDTH(1)) u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (pll_locked_i),
      .q     (lk_s)
   );

   assign fsm_state = state;

   // Next-state, shared counter and retry bookkeeping.
   always_comb begin
      state_next = state;
      cnt_next   = cnt + CNT_W'(1);
      retry_next = retry_cnt_o;
      case (state)
         RESET_PLL: begin
            if (cnt == RST_LAST) state_next = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lk_s) begin
               state_next = STABLE;
            end else if (cnt == TMO_LAST) begin
               // A timed-out attempt is the only thing that counts as a failure.
               retry_next = (retry_cnt_o == RETRY_SAT) ? retry_cnt_o : retry_cnt_o + 4'd1;
               state_next = (retry_next > MAX_R) ? FAULT : RESET_PLL;
            end
         end
         STABLE: begin
            // Any drop of lock during qualification goes back to waiting, no penalty.
            if (!lk_s)                state_next = WAIT_LOCK;
            else if (cnt == STB_LAST) state_next = RUN;
         end
         RUN: begin
            // Lock loss and relock request share one path; both together are one event.
            cnt_next = cnt;
            if (!lk_s || relock_req_i) state_next = RESET_PLL;
         end
         FAULT: begin
            cnt_next = cnt;
         end
         default: begin
            state_next = RESET_PLL;
         end
      endcase
      // Every state entry starts the shared counter from zero.
      if (state_next != state) cnt_next = '0;
   end

   // State, counters and the registered output decode.
   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         state       <= RESET_PLL;
         cnt         <= '0;
         retry_cnt_o <= '0;
         pll_rst_o   <= 1'b1;
         sys_rst_n_o <= 1'b0;
         pll_ready_o <= 1'b0;
         fault_o     <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         retry_cnt_o <= retry_next;
         pll_rst_o   <= (state_next == RESET_PLL) || (state_next == FAULT);
         sys_rst_n_o <= (state_next == RUN);
         pll_ready_o <= (state_next == RUN);
         fault_o     <= (state_next == FAULT);
      end
   end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer with short timing (4/8/32, 2 retries).
module tb_pll_lock_sequencer;
   import pll_seq_pkg::*;

   localparam int RP = 4;
   localparam int LS = 8;
   localparam int LT = 32;
   localparam int MR = 2;

   // ---------------- clock / reset / DUT ----------------
   logic       refclk = 1'b0;
   logic       rst_n;
   logic       pll_locked;
   logic       relock_req;
   logic       pll_rst_o, sys_rst_n_o, pll_ready_o, fault_o;
   logic [3:0] retry_cnt_o;
   logic [2:0] fsm_state;

   always #5 refclk = ~refclk;

   pll_lock_sequencer #(
      .RST_PULSE_CYC    (RP),
      .LOCK_STABLE_CYC  (LS),
      .LOCK_TIMEOUT_CYC (LT),
      .MAX_RETRIES      (MR)
   ) dut (
      .refclk       (refclk),
      .rst_n        (rst_n),
      .pll_locked_i (pll_locked),
      .relock_req_i (relock_req),
      .pll_rst_o    (pll_rst_o),
      .sys_rst_n_o  (sys_rst_n_o),
      .pll_ready_o  (pll_ready_o),
      .fault_o      (fault_o),
      .retry_cnt_o  (retry_cnt_o),
      .fsm_state    (fsm_state)
   );

   int total = 0;
   int bad   = 0;

   function automatic logic [7:0] outs();
      return {pll_rst_o, sys_rst_n_o, pll_ready_o, fault_o, retry_cnt_o};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- driver ----------------
   task automatic apply(input logic r, input logic l, input logic q, input int n);
      rst_n      = r;
      pll_locked = l;
      relock_req = q;
      repeat (n) @(negedge refclk);
   endtask

   // ---------------- reference model + scoreboard ----------------
   // Phases of the bring-up, tracked with elapsed-cycle counts; lock is seen
   // two samples late, which the history queue models directly.
   localparam int M_PULSE = 0, M_WAIT = 1, M_QUAL = 2, M_RUN = 3, M_FAULT = 4;
   int   phase, elapsed, retries;
   logic hist[$];
   logic [7:0] exp_q[$];

   always @(posedge refclk) begin : ref_model
      logic lk;
      if (!rst_n) begin
         phase = M_PULSE; elapsed = 0; retries = 0;
         hist = '{1'b0, 1'b0};
      end else begin
         lk = hist[0];
         hist = '{hist[1], pll_locked};
         case (phase)
            M_PULSE: begin
               elapsed++;
               if (elapsed == RP) begin phase = M_WAIT; elapsed = 0; end
            end
            M_WAIT: begin
               if (lk) begin
                  phase = M_QUAL; elapsed = 0;
               end else begin
                  elapsed++;
                  if (elapsed == LT) begin
                     retries = (retries < 15) ? retries + 1 : 15;
                     phase   = (retries > MR) ? M_FAULT : M_PULSE;
                     elapsed = 0;
                  end
               end
            end
            M_QUAL: begin
               if (!lk) begin
                  phase = M_WAIT; elapsed = 0;
               end else begin
                  elapsed++;
                  if (elapsed == LS) begin phase = M_RUN; elapsed = 0; end
               end
            end
            M_RUN: begin
               if (!lk || relock_req) begin phase = M_PULSE; elapsed = 0; end
            end
            default: ;
         endcase
      end
      exp_q.push_back({(phase == M_PULSE) || (phase == M_FAULT), phase == M_RUN,
                       phase == M_RUN, phase == M_FAULT, 4'(retries)});
   end

   // Compare every cycle away from the active edge.
   always @(negedge refclk) begin
      if (exp_q.size() > 0) check("model", 32'(outs()), 32'(exp_q.pop_front()));
   end

   // ---------------- vector table ----------------
   typedef struct {
      int         cycles;
      logic       rst_n;
      logic       locked;
      logic       relock;
      logic [7:0] exp;   // {pll_rst, sys_rst_n, ready, fault, retry[3:0]}
   } vec_t;

   vec_t vecs[17];

   initial begin
      rst_n = 1'b0; pll_locked = 1'b0; relock_req = 1'b0;

      // Clean lock, relock request, one-cycle lock loss and resequence.
      vecs[0]  = '{2, 1'b0, 1'b0, 1'b0, 8'b1000_0000}; // reset values
      vecs[1]  = '{3, 1'b1, 1'b0, 1'b0, 8'b1000_0000}; // pulse still high
      vecs[2]  = '{1, 1'b1, 1'b0, 1'b0, 8'b0000_0000}; // 4th edge: pll_rst falls
      vecs[3]  = '{2, 1'b1, 1'b1, 1'b0, 8'b0000_0000}; // lock in synchroniser
      vecs[4]  = '{1, 1'b1, 1'b1, 1'b0, 8'b0000_0000}; // enters STABLE
      vecs[5]  = '{7, 1'b1, 1'b1, 1'b0, 8'b0000_0000}; // qualifying
      vecs[6]  = '{1, 1'b1, 1'b1, 1'b0, 8'b0110_0000}; // 11 edges after lock: RUN
      vecs[7]  = '{1, 1'b1, 1'b1, 1'b1, 8'b1000_0000}; // relock request
      vecs[8]  = '{4, 1'b1, 1'b1, 1'b0, 8'b0000_0000}; // 4-cycle pulse done
      vecs[9]  = '{1, 1'b1, 1'b1, 1'b0, 8'b0000_0000}; // STABLE
      vecs[10] = '{7, 1'b1, 1'b1, 1'b0, 8'b0000_0000};
      vecs[11] = '{1, 1'b1, 1'b1, 1'b0, 8'b0110_0000}; // RUN again
      vecs[12] = '{1, 1'b1, 1'b0, 1'b0, 8'b0110_0000}; // lock drops one cycle
      vecs[13] = '{1, 1'b1, 1'b1, 1'b0, 8'b0110_0000};
      vecs[14] = '{1, 1'b1, 1'b1, 1'b0, 8'b1000_0000}; // 3rd edge: back to reset
      vecs[15] = '{4, 1'b1, 1'b1, 1'b0, 8'b0000_0000};
      vecs[16] = '{9, 1'b1, 1'b1, 1'b0, 8'b0110_0000}; // retry count unchanged

      for (int i = 0; i < 17; i++) begin
         apply(vecs[i].rst_n, vecs[i].locked, vecs[i].relock, vecs[i].cycles);
         check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      end

      // No lock ever: three attempts, then FAULT with pll_rst held.
      apply(1'b0, 1'b0, 1'b0, 2);
      apply(1'b1, 1'b0, 1'b0, RP + LT);
      check("nolock_retry1", 32'(retry_cnt_o), 32'd1);
      check("nolock_pulse2", 32'(pll_rst_o), 32'd1);
      apply(1'b1, 1'b0, 1'b0, RP + LT);
      check("nolock_retry2", 32'(retry_cnt_o), 32'd2);
      apply(1'b1, 1'b0, 1'b0, RP + LT - 1);
      check("nolock_prefault", 32'(outs()), 32'(8'b0000_0010));
      apply(1'b1, 1'b0, 1'b0, 1);
      check("nolock_fault", 32'(outs()), 32'(8'b1001_0011));
      apply(1'b1, 1'b1, 1'b1, 20);
      check("fault_sticky", 32'(outs()), 32'(8'b1001_0011));
      // Reset out of FAULT.
      apply(1'b0, 1'b1, 1'b0, 1);
      check("rst_in_fault", 32'(outs()), 32'(8'b1000_0000));
      check("rst_in_fault_state", 32'(fsm_state), 32'(RESET_PLL));

      // Reset while in STABLE.
      apply(1'b0, 1'b1, 1'b0, 1);
      apply(1'b1, 1'b1, 1'b0, RP + 1);
      check("stable_reached", 32'(fsm_state), 32'(STABLE));
      apply(1'b0, 1'b1, 1'b0, 1);
      check("rst_in_stable", 32'(outs()), 32'(8'b1000_0000));
      check("rst_in_stable_state", 32'(fsm_state), 32'(RESET_PLL));

      // Relock pulse in WAIT_LOCK is ignored and not queued.
      apply(1'b0, 1'b0, 1'b0, 1);
      apply(1'b1, 1'b0, 1'b0, RP + 1);
      apply(1'b1, 1'b0, 1'b1, 1);
      check("relock_wait_state", 32'(fsm_state), 32'(WAIT_LOCK));
      check("relock_wait_rst", 32'(pll_rst_o), 32'd0);
      apply(1'b1, 1'b1, 1'b0, 10);
      check("relock_wait_pre", 32'(sys_rst_n_o), 32'd0);
      apply(1'b1, 1'b1, 1'b0, 1);
      check("relock_wait_run", 32'(sys_rst_n_o), 32'd1);
      apply(1'b1, 1'b1, 1'b0, 5);
      check("relock_not_queued", 32'(outs()), 32'(8'b0110_0000));

      // Glitchy lock: high 5, low 1, high again.
      apply(1'b0, 1'b0, 1'b0, 1);
      apply(1'b1, 1'b0, 1'b0, RP + 2);
      apply(1'b1, 1'b1, 1'b0, 5);
      apply(1'b1, 1'b0, 1'b0, 1);
      check("glitch_stable", 32'(fsm_state), 32'(STABLE));
      apply(1'b1, 1'b1, 1'b0, 1);
      check("glitch_still", 32'(fsm_state), 32'(STABLE));
      apply(1'b1, 1'b1, 1'b0, 1);
      check("glitch_abort", 32'(fsm_state), 32'(WAIT_LOCK));
      apply(1'b1, 1'b1, 1'b0, 8);
      check("glitch_pre", 32'(sys_rst_n_o), 32'd0);
      apply(1'b1, 1'b1, 1'b0, 1);
      check("glitch_run", 32'(outs()), 32'(8'b0110_0000));

      // Random segments of lock/unlock with sporadic relock and reset.
      apply(1'b0, 1'b0, 1'b0, 2);
      for (int cyc = 0; cyc < 4000; ) begin
         int   len;
         logic lv;
         len = $urandom_range(1, 40);
         lv  = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < len; i++) begin
            apply(($urandom_range(0, 399) != 0), lv, ($urandom_range(0, 15) == 0), 1);
         end
         cyc += len;
      end

      apply(1'b1, 1'b0, 1'b0, 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
